// File: rtl/axil_slave_regs.sv
// AXI4-Lite register slave: NUM_REGS x 32-bit R/W regs, parallel out + write pulses.
// Define AXIL_SLAVE_REGS_WSTRB_EN to honour wstrb byte lanes; otherwise writes are full-word.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        awvalid;
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic        rready;
  } s_axil_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } s_axil_miso_t;
endpackage

module axil_slave_regs
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                          aclk,
  input  logic                          arst,
  input  logic [$bits(s_axil_mosi_t)-1:0] axil_mosi_i,
  output logic [$bits(s_axil_miso_t)-1:0] axil_miso_o,
  output logic [NUM_REGS*32-1:0]        regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse_o
);

  localparam int          IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  s_axil_mosi_t req;
  s_axil_miso_t rsp;
  assign req         = axil_mosi_i;
  assign axil_miso_o = rsp;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                          rdy_en;
  logic                          aw_held, w_held;
  logic [7:0]                    awid_q;
  logic [31:0]                   awaddr_q, wdata_q;
  logic [NUM_REGS-1:0][31:0]     regs_q;
  logic [NUM_REGS-1:0]           wr_pulse_q;
  logic [7:0]                    bid_q, rid_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [31:0]                   rdata_q;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [7:0]  wid;
  logic [31:0] waddr, wdata, woff, roff;
  logic [3:0]  be;
  logic        wsel, rsel;
  logic [IW-1:0] widx, ridx;

`ifdef AXIL_SLAVE_REGS_WSTRB_EN
  logic [3:0] wstrb_q;
  assign be = w_held ? wstrb_q : req.wstrb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req.wstrb;
  assign be = 4'hF;
`endif

  assign awready = rdy_en && (w_state == W_IDLE) && !aw_held;
  assign wready  = rdy_en && (w_state == W_IDLE) && !w_held;
  assign arready = rdy_en && (r_state == R_IDLE);
  assign aw_hs   = req.awvalid && awready;
  assign w_hs    = req.wvalid && wready;
  assign ar_hs   = req.arvalid && arready;

  // Commit as soon as both halves are present, held or live.
  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign waddr = aw_held ? awaddr_q : req.awaddr;
  assign wid   = aw_held ? awid_q : req.awid;
  assign wdata = w_held ? wdata_q : req.wdata;
  assign woff  = waddr - BASE_ADDR;
  assign roff  = req.araddr - BASE_ADDR;
  assign wsel  = woff < SPAN;
  assign rsel  = roff < SPAN;
  assign widx  = woff[2 +: IW];
  assign ridx  = roff[2 +: IW];

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (commit) w_next = W_RESP;
      W_RESP: if (req.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (req.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      rdy_en     <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      awid_q     <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef AXIL_SLAVE_REGS_WSTRB_EN
      wstrb_q    <= '0;
`endif
      regs_q     <= {NUM_REGS{RESET_VAL}};
      wr_pulse_q <= '0;
      bid_q      <= '0;
      bresp_q    <= '0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      rdy_en     <= 1'b1;
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awid_q   <= req.awid;
        awaddr_q <= req.awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= req.wdata;
`ifdef AXIL_SLAVE_REGS_WSTRB_EN
        wstrb_q <= req.wstrb;
`endif
      end
      if (w_state == W_RESP && req.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (commit) begin
        bid_q   <= wid;
        bresp_q <= wsel ? RESP_OKAY : RESP_DECERR;
        if (wsel) begin
          for (int j = 0; j < 4; j++)
            if (be[j]) regs_q[widx][8*j +: 8] <= wdata[8*j +: 8];
          wr_pulse_q[widx] <= 1'b1;
        end
      end
      // Reads sample pre-commit contents on a shared edge.
      if (ar_hs) begin
        rid_q   <= req.arid;
        rresp_q <= rsel ? RESP_OKAY : RESP_DECERR;
        rdata_q <= rsel ? regs_q[ridx] : 32'h0;
      end
    end
  end

  always_comb begin
    rsp         = '0;
    rsp.awready = awready;
    rsp.wready  = wready;
    rsp.bvalid  = (w_state == W_RESP);
    rsp.bid     = bid_q;
    rsp.bresp   = bresp_q;
    rsp.arready = arready;
    rsp.rvalid  = (r_state == R_DATA);
    rsp.rid     = rid_q;
    rsp.rdata   = rdata_q;
    rsp.rresp   = rresp_q;
  end

  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed bench for axil_slave_regs (NUM_REGS = 8, BASE_ADDR = 0).
// Expected register values are tracked in a small local array.
module tb_axil_slave_regs;
  import axil_pkg::*;

  logic         aclk = 1'b0;
  logic         arst;
  s_axil_mosi_t mosi;
  s_axil_miso_t miso;
  logic [255:0] regs;
  logic [7:0]   pulse;
  logic [31:0]  m [8];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  axil_slave_regs #(
    .BASE_ADDR(32'h0),
    .NUM_REGS (8),
    .RESET_VAL(32'h0)
  ) dut (
    .aclk       (aclk),
    .arst       (arst),
    .axil_mosi_i(mosi),
    .axil_miso_o(miso),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d", tag, i), 64'(regs[32*i +: 32]), 64'(m[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    arst = 1'b1;
    mosi = '0;
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    repeat (3) tick;
    chk("rst_awready", 64'(miso.awready), 64'd0);
    chk("rst_arready", 64'(miso.arready), 64'd0);

    arst = 1'b0;
    tick;
    chk("rel_awready", 64'(miso.awready), 64'd1);
    chk("rel_wready", 64'(miso.wready), 64'd1);
    chk("rel_arready", 64'(miso.arready), 64'd1);
    chk("rel_bvalid", 64'(miso.bvalid), 64'd0);
    chk("rel_rvalid", 64'(miso.rvalid), 64'd0);
    chk_regs("rel");

    // AW and W together
    mosi.awvalid = 1'b1; mosi.awaddr = 32'h4; mosi.awid = 8'h12;
    mosi.wvalid = 1'b1; mosi.wdata = 32'hDEADBEEF; mosi.wstrb = 4'hF;
    mosi.bready = 1'b1;
    tick;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    m[1] = 32'hDEADBEEF;
    chk("w1_bvalid", 64'(miso.bvalid), 64'd1);
    chk("w1_bid", 64'(miso.bid), 64'h12);
    chk("w1_bresp", 64'(miso.bresp), 64'd0);
    chk("w1_awready", 64'(miso.awready), 64'd0);
    chk("w1_pulse", 64'(pulse), 64'h02);
    chk_regs("w1");
    tick;
    chk("w1_bdone", 64'(miso.bvalid), 64'd0);
    chk("w1_pulse_off", 64'(pulse), 64'h00);
    chk("w1_awready_back", 64'(miso.awready), 64'd1);

    // W first, AW three cycles later
    mosi.bready = 1'b0;
    mosi.wvalid = 1'b1; mosi.wdata = 32'h11223344; mosi.wstrb = 4'b0101;
    tick;
    mosi.wvalid = 1'b0;
    chk("w2_wready_held", 64'(miso.wready), 64'd0);
    chk("w2_awready", 64'(miso.awready), 64'd1);
    chk("w2_bvalid_early", 64'(miso.bvalid), 64'd0);
    tick;
    tick;
    mosi.awvalid = 1'b1; mosi.awaddr = 32'h8; mosi.awid = 8'h21;
    tick;
    mosi.awvalid = 1'b0;
`ifdef AXIL_SLAVE_REGS_WSTRB_EN
    m[2] = 32'h00220044;
`else
    m[2] = 32'h11223344;
`endif
    chk("w2_bvalid", 64'(miso.bvalid), 64'd1);
    chk("w2_bid", 64'(miso.bid), 64'h21);
    chk("w2_pulse", 64'(pulse), 64'h04);
    chk_regs("w2");
    tick;
    chk("w2_bhold", 64'(miso.bvalid), 64'd1);
    mosi.bready = 1'b1;
    tick;
    chk("w2_bdone", 64'(miso.bvalid), 64'd0);

    // Read with rready held off
    mosi.arvalid = 1'b1; mosi.araddr = 32'h4; mosi.arid = 8'h7;
    mosi.rready = 1'b0;
    tick;
    mosi.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r1_rvalid%0d", i), 64'(miso.rvalid), 64'd1);
      chk($sformatf("r1_rdata%0d", i), 64'(miso.rdata), 64'hDEADBEEF);
      chk($sformatf("r1_rid%0d", i), 64'(miso.rid), 64'h7);
      chk($sformatf("r1_arready%0d", i), 64'(miso.arready), 64'd0);
      if (i == 3) mosi.rready = 1'b1;
      tick;
    end
    chk("r1_rdone", 64'(miso.rvalid), 64'd0);
    chk("r1_arready_back", 64'(miso.arready), 64'd1);

    // Out-of-range write and read
    mosi.awvalid = 1'b1; mosi.awaddr = 32'h40; mosi.awid = 8'h5;
    mosi.wvalid = 1'b1; mosi.wdata = 32'hCAFEF00D; mosi.wstrb = 4'hF;
    mosi.arvalid = 1'b1; mosi.araddr = 32'h40; mosi.arid = 8'h3;
    tick;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
    chk("oor_bvalid", 64'(miso.bvalid), 64'd1);
    chk("oor_bresp", 64'(miso.bresp), 64'd3);
    chk("oor_bid", 64'(miso.bid), 64'h5);
    chk("oor_rvalid", 64'(miso.rvalid), 64'd1);
    chk("oor_rresp", 64'(miso.rresp), 64'd3);
    chk("oor_rdata", 64'(miso.rdata), 64'd0);
    chk("oor_rid", 64'(miso.rid), 64'h3);
    chk("oor_pulse", 64'(pulse), 64'h00);
    chk_regs("oor");
    tick;
    chk("oor_bdone", 64'(miso.bvalid), 64'd0);
    chk("oor_rdone", 64'(miso.rvalid), 64'd0);

    // Preload reg3
    mosi.awvalid = 1'b1; mosi.awaddr = 32'hC; mosi.awid = 8'h1;
    mosi.wvalid = 1'b1; mosi.wdata = 32'h12345678; mosi.wstrb = 4'hF;
    tick;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    m[3] = 32'h12345678;
    tick;
    chk_regs("pre");

    // Read and write commit on the same edge, then reset with B pending
    mosi.bready = 1'b0; mosi.rready = 1'b0;
    mosi.awvalid = 1'b1; mosi.awaddr = 32'hC; mosi.awid = 8'h2;
    mosi.wvalid = 1'b1; mosi.wdata = 32'h55; mosi.wstrb = 4'hF;
    mosi.arvalid = 1'b1; mosi.araddr = 32'hC; mosi.arid = 8'h9;
    tick;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
    m[3] = 32'h55;
    chk("rw_rdata_old", 64'(miso.rdata), 64'h12345678);
    chk("rw_rvalid", 64'(miso.rvalid), 64'd1);
    chk("rw_bvalid", 64'(miso.bvalid), 64'd1);
    chk("rw_pulse", 64'(pulse), 64'h08);
    chk_regs("rw");

    arst = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    chk("mrst_bvalid", 64'(miso.bvalid), 64'd0);
    chk("mrst_rvalid", 64'(miso.rvalid), 64'd0);
    chk("mrst_awready", 64'(miso.awready), 64'd0);
    chk("mrst_pulse", 64'(pulse), 64'h00);
    chk_regs("mrst");
    arst = 1'b0;
    tick;
    chk("mrel_awready", 64'(miso.awready), 64'd1);
    chk("mrel_wready", 64'(miso.wready), 64'd1);
    chk("mrel_bvalid", 64'(miso.bvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_slave_regs.md
Name: axil_slave_regs

Overview:
- AXI4-Lite responder (slave end) exposing NUM_REGS 32-bit read/write registers to an AXI4-Lite initiator.
- Uses the package AXI-Lite request/response structs: request in, response out.
- Registers are also driven out in parallel to local hardware, with a per-register write strobe pulse.
- Sits behind an interconnect as the control/status endpoint of a peripheral.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be NUM_REGS*4 aligned.
- NUM_REGS, 8: number of 32-bit registers (power of two, 2..256).
- RESET_VAL, 32'h0: reset value of every register.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- axil_mosi_i  in  $bits(s_axil_mosi_t)  AXI4-Lite request channels (AW, W, B-ready, AR, R-ready).
- axil_miso_o  out  $bits(s_axil_miso_t)  AXI4-Lite response channels (ready signals, B, R).
- regs_o  out  NUM_REGS*32  register contents; reg i at [32*i+:32].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse when reg i is written.

Behaviour:
- Reset (arst high at an edge):
  - all axil_miso_o fields 0; regs = RESET_VAL; wr_pulse_o = 0; both FSMs idle; held AW/W cleared.
  - Readies are 0 while arst is high and 1 from the first cycle after release.
  - Reset mid-transaction drops any pending B/R response without completing it.
- Address decode:
  - off = addr - BASE_ADDR; in range iff off < NUM_REGS*4; index = off[2+:log2(NUM_REGS)].
  - addr[1:0] ignored (no alignment error).
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held; wready = !w_held. AW and W are accepted independently in either order or the same cycle; each is held once taken (awid, awaddr / wdata, wstrb).
  - Commit on the edge where both are present (held or handshaking). In range: byte j of reg[index] <= wdata byte j where wstrb[j]; wr_pulse_o[index] = 1 next cycle. Out of range: no register change, no pulse.
  - Then go to W_RESP: bvalid = 1; bid = captured awid; bresp = OKAY, or DECERR if out of range. awready = wready = 0.
  - bvalid and the B fields hold stable until bready; on the bvalid&&bready edge go to W_IDLE and clear held flags.
  - Latency: AW+W same edge k -> bvalid and updated register at k+1. Min throughput: one write per 2 cycles.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready = 1. On the arvalid&&arready edge, capture rdata = reg[index] (value before any write committing that same edge), rid = arid, rresp = OKAY, or DECERR with rdata = 0 if out of range. Go to R_DATA.
  - R_DATA: rvalid = 1, arready = 0; outputs stable until rready; on handshake go to R_IDLE.
  - Latency: AR accepted at edge k -> rvalid at k+1.
- Read and write FSMs are fully independent; concurrent traffic to the same register is legal.
- wr_pulse_o is one-hot or zero.
- Unused miso fields are 0.
- bvalid/rvalid never drop without the matching ready.

Optional Feature:
- Macro AXIL_SLAVE_REGS_WSTRB_EN.
- Defined: byte-lane writes honour wstrb as above.
- Undefined: wstrb is ignored and every accepted in-range write updates all 4 bytes, including wstrb = 4'b0000.

Test Plan:
- Reset then idle -> regs_o all 0; awready/wready/arready = 1 on the first cycle after arst falls; bvalid = rvalid = 0.
- AW(addr 0x4, id 0x12) and W(0xDEADBEEF, strb 0xF) same cycle, bready = 1 -> next cycle bvalid = 1, bid = 0x12, bresp = OKAY, regs_o[63:32] = 0xDEADBEEF, wr_pulse_o = 8'h02.
- W first (0x11223344, strb 4'b0101), AW 3 cycles later to 0x8 over prior value 0 -> reg2 = 0x00220044 with WSTRB_EN; 0x11223344 without it. B issued one cycle after the AW handshake.
- AR to 0x4 (id 0x7) with rready held low 4 cycles -> rvalid, rdata = 0xDEADBEEF, rid = 0x7 stable all 4 cycles; arready = 0 until the handshake.
- Write and read to 0x40 (out of range, NUM_REGS = 8) -> bresp = DECERR, rresp = DECERR, rdata = 0, no wr_pulse, regs unchanged.
- AR to 0xC on the same edge as a write commit of 0x55 to 0xC -> rdata = old value; arst asserted while bvalid is pending -> bvalid = 0 next cycle and regs = 0.
